// File: rtl/counter_sched.sv
// Round-robin scheduler that serialises inc/dec/clear/read commands from N_REQ requesters
// onto a shared bank of N_CNT counters. Define COUNTER_SCHED_SAT_EN for saturating inc/dec.
module counter_sched #(
   parameter int N_REQ = 4,
   parameter int N_CNT = 8,
   parameter int CNT_W = 8,
   localparam int IDX_W = $clog2(N_CNT),
   localparam int REQ_W = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   sched_en,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [2*N_REQ-1:0]     req_op,
   input  logic [IDX_W*N_REQ-1:0] req_idx,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   done_valid,
   output logic [REQ_W-1:0]       done_req,
   output logic [CNT_W-1:0]       done_value,
   output logic                   done_wrap,
   input  logic [IDX_W-1:0]       rd_idx,
   output logic [CNT_W-1:0]       rd_data
);

   localparam logic [1:0] OP_INC = 2'b00;
   localparam logic [1:0] OP_DEC = 2'b01;
   localparam logic [1:0] OP_CLR = 2'b10;
   localparam logic [1:0] OP_RD  = 2'b11;

   logic [CNT_W-1:0] cnt [N_CNT];
   logic [REQ_W-1:0] rr_ptr;

   logic             grant_any;
   logic [REQ_W-1:0] grant_id;
   logic [1:0]       op_sel;
   logic [IDX_W-1:0] idx_sel;
   logic             idx_ok;
   logic [CNT_W-1:0] cur_val;
   logic [CNT_W-1:0] nxt_val;
   logic             nxt_wrap;

   // First valid requester at or above rr_ptr, wrapping; reset forces no grant.
   always_comb begin
      int cand;
      grant_any = 1'b0;
      grant_id  = '0;
      req_ready = '0;
      cand      = 0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = int'(rr_ptr) + i;
         if (cand >= N_REQ) cand = cand - N_REQ;
         if (!grant_any && rst_n && sched_en && req_valid[cand]) begin
            grant_any       = 1'b1;
            grant_id        = REQ_W'(cand);
            req_ready[cand] = 1'b1;
         end
      end
   end

   always_comb begin
      op_sel  = req_op[grant_id*2 +: 2];
      idx_sel = req_idx[grant_id*IDX_W +: IDX_W];
      idx_ok  = (int'(idx_sel) < N_CNT);
      cur_val = idx_ok ? cnt[idx_sel] : '0;
   end

   always_comb begin
      nxt_val  = cur_val;
      nxt_wrap = 1'b0;
      case (op_sel)
         OP_INC: begin
            nxt_wrap = &cur_val;
`ifdef COUNTER_SCHED_SAT_EN
            nxt_val  = (&cur_val) ? cur_val : cur_val + CNT_W'(1);
`else
            nxt_val  = cur_val + CNT_W'(1);
`endif
         end
         OP_DEC: begin
            nxt_wrap = (cur_val == '0);
`ifdef COUNTER_SCHED_SAT_EN
            nxt_val  = (cur_val == '0) ? cur_val : cur_val - CNT_W'(1);
`else
            nxt_val  = cur_val - CNT_W'(1);
`endif
         end
         OP_CLR:  nxt_val = '0;
         OP_RD:   nxt_val = cur_val;
         default: nxt_val = cur_val;
      endcase
      // Out-of-range commands complete with a zero result and touch nothing.
      if (!idx_ok) begin
         nxt_val  = '0;
         nxt_wrap = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
         for (int k = 0; k < N_CNT; k++) cnt[k] <= '0;
      end else if (grant_any) begin
         rr_ptr <= (grant_id == REQ_W'(N_REQ - 1)) ? '0 : grant_id + REQ_W'(1);
         if (idx_ok) cnt[idx_sel] <= nxt_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_valid <= 1'b0;
         done_req   <= '0;
         done_value <= '0;
         done_wrap  <= 1'b0;
      end else begin
         done_valid <= grant_any;
         if (grant_any) begin
            done_req   <= grant_id;
            done_value <= nxt_val;
            done_wrap  <= nxt_wrap;
         end
      end
   end

   assign rd_data = (int'(rd_idx) < N_CNT) ? cnt[rd_idx] : '0;

endmodule

// File: tb/tb_counter_sched.sv
// Scoreboard bench for counter_sched: stimulus pushes hand-computed completions,
// a negedge monitor pops and compares them against the done_* outputs.
module tb_counter_sched;

`ifdef COUNTER_SCHED_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sched_en = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [7:0]  req_op = '0;
   logic [11:0] req_idx = '0;
   logic [3:0]  req_ready;
   logic        done_valid;
   logic [1:0]  done_req;
   logic [7:0]  done_value;
   logic        done_wrap;
   logic [2:0]  rd_idx = '0;
   logic [7:0]  rd_data;

   typedef struct packed {
      logic [1:0] req;
      logic [7:0] val;
      logic       wrap;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   passed = 0;

   counter_sched dut (
      .clk(clk), .rst_n(rst_n), .sched_en(sched_en),
      .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
      .req_ready(req_ready), .done_valid(done_valid), .done_req(done_req),
      .done_value(done_value), .done_wrap(done_wrap),
      .rd_idx(rd_idx), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Each queued completion is due at the first negedge after its accept edge.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (sb.size() == 0) begin
            if (done_valid) begin
               total++;
               $display("FAIL unexpected_done: got req %0d value %0h, expected no done", done_req, done_value);
            end
         end else begin
            e = sb.pop_front();
            check("done_valid", 32'(done_valid), 32'd1);
            check("done_req", 32'(done_req), 32'(e.req));
            check("done_value", 32'(done_value), 32'(e.val));
            check("done_wrap", 32'(done_wrap), 32'(e.wrap));
         end
      end
   end

   task automatic drive(input logic [3:0] v, input logic [7:0] op, input logic [11:0] idx);
      req_valid = v;
      req_op    = op;
      req_idx   = idx;
   endtask

   task automatic tick(input string name, input logic [3:0] exp_ready, input bit push,
                       input logic [1:0] r, input logic [7:0] v, input logic w);
      exp_t e;
      #1;
      check(name, 32'(req_ready), 32'(exp_ready));
      if (push) begin
         e.req = r; e.val = v; e.wrap = w;
         sb.push_back(e);
      end
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] ev;
      logic       ew;
      drive(4'b1111, 8'h00, 12'h000);
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_done", 32'(done_valid), 32'd0);
      rst_n    = 1'b1;
      sched_en = 1'b1;

      // All requesters INC counter 0: strict rotation, values 1..8
      for (int k = 1; k <= 8; k++) begin
         ev = 8'(k);
         tick("t2_ready", 4'(1 << ((k - 1) % 4)), 1'b1, 2'((k - 1) % 4), ev, 1'b0);
      end
      rd_idx = 3'd0;
      #1 check("t2_cnt0", 32'(rd_data), 32'd8);

      // Reset right after req1 is accepted: its done pulse must vanish, rr back to 0
      drive(4'b0010, 8'h00, 12'(1 << 3));
      #1 check("t1_ready_pre", 32'(req_ready), 32'b0010);
      @(posedge clk);
      #1 rst_n = 1'b0;
      sb.delete();
      #1;
      check("t1_done_rst", 32'(done_valid), 32'd0);
      check("t1_ready_rst", 32'(req_ready), 32'd0);
      rd_idx = 3'd0;
      #1 check("t1_cnt0", 32'(rd_data), 32'd0);
      rd_idx = 3'd1;
      #1 check("t1_cnt1", 32'(rd_data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b1111, 8'hFF, 12'h000);
      tick("t1_first_grant", 4'b0001, 1'b1, 2'd0, 8'h00, 1'b0);

      // DEC of a zero counter by req1
      drive(4'b0010, 8'b0000_0100, 12'(3 << 3));
      ev = SAT ? 8'h00 : 8'hFF;
      tick("t4_ready", 4'b0010, 1'b1, 2'd1, ev, 1'b1);
      rd_idx = 3'd3;
      #1 check("t4_cnt3", 32'(rd_data), 32'(ev));

      // Load counter 2 with 7, then CLR and RD back-to-back
      drive(4'b0001, 8'h00, 12'd2);
      for (int k = 1; k <= 7; k++) tick("t6_load", 4'b0001, 1'b1, 2'd0, 8'(k), 1'b0);
      drive(4'b0001, 8'b0000_0010, 12'd2);
      rd_idx = 3'd2;
      #1 check("t6_rd_old", 32'(rd_data), 32'd7);
      tick("t6_clr", 4'b0001, 1'b1, 2'd0, 8'h00, 1'b0);
      drive(4'b0010, 8'b0000_1100, 12'(2 << 3));
      #1 check("t6_rd_new", 32'(rd_data), 32'd0);
      tick("t6_rd", 4'b0010, 1'b1, 2'd1, 8'h00, 1'b0);

      // Scheduler disabled: no grants, no done, rr held at 2
      sched_en = 1'b0;
      drive(4'b1111, 8'h00, 12'h000);
      for (int k = 0; k < 5; k++) tick("t5_disabled", 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
      rd_idx = 3'd0;
      #1 check("t5_cnt0", 32'(rd_data), 32'd0);
      sched_en = 1'b1;
      tick("t5_resume", 4'b0100, 1'b1, 2'd2, 8'd1, 1'b0);
      tick("t5_next", 4'b1000, 1'b1, 2'd3, 8'd2, 1'b0);
      // Disabling after an accept still lets that done through
      sched_en = 1'b0;
      tick("t5_off", 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
      sched_en = 1'b1;

      // req2 INC counter 5 past all-ones
      drive(4'b0100, 8'h00, 12'(5 << 6));
      for (int k = 1; k <= 257; k++) begin
         if (SAT) begin
            ev = (k >= 255) ? 8'hFF : 8'(k);
            ew = (k >= 256);
         end else begin
            ev = 8'(k);
            ew = (k == 256);
         end
         tick("t3_inc", 4'b0100, 1'b1, 2'd2, ev, ew);
      end
      drive(4'b0000, 8'h00, 12'h000);
      repeat (3) tick("drain", 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
      rd_idx = 3'd5;
      #1 check("t3_cnt5", 32'(rd_data), SAT ? 32'hFF : 32'h01);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
